// File: rtl/pipe_id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct values, ALU and
// PC-source encodings, and the instruction decoder used by pipe_id.
package pipe_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_LUI = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8
    } aluc_e;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JR = 2'd2, PC_JMP = 2'd3
    } pcsrc_e;

    typedef enum logic [1:0] { RN_RD = 2'd0, RN_RT = 2'd1, RN_31 = 2'd2 } rnsel_e;

    typedef struct packed {
        logic   wreg;
        logic   m2reg;
        logic   wmem;
        logic   aluimm;
        logic   shift;
        logic   jal;
        logic   zext;
        logic   uses_rs;
        logic   uses_rt;
        logic   is_beq;
        logic   is_bne;
        logic   is_jr;
        logic   is_j;
        aluc_e  aluc;
        rnsel_e rn_sel;
    } ctrl_t;

    // The all-zero word is treated as a true nop rather than "sll r0,r0,0"
    // so that a reset IF/ID register drives every control low.
    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] fn;
        c  = '0;
        op = inst[31:26];
        fn = inst[5:0];
        if (inst != 32'd0) begin
            case (op)
                OP_RTYPE: begin
                    c.wreg = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.rn_sel = RN_RD;
                    case (fn)
                        FN_ADD: c.aluc = ALU_ADD;
                        FN_SUB: c.aluc = ALU_SUB;
                        FN_AND: c.aluc = ALU_AND;
                        FN_OR:  c.aluc = ALU_OR;
                        FN_XOR: c.aluc = ALU_XOR;
                        FN_SLL: begin c.aluc = ALU_SLL; c.shift = 1'b1; c.uses_rs = 1'b0; end
                        FN_SRL: begin c.aluc = ALU_SRL; c.shift = 1'b1; c.uses_rs = 1'b0; end
                        FN_SRA: begin c.aluc = ALU_SRA; c.shift = 1'b1; c.uses_rs = 1'b0; end
                        FN_JR:  begin c.wreg = 1'b0; c.uses_rt = 1'b0; c.is_jr = 1'b1; end
                        default: begin c.wreg = 1'b0; c.uses_rs = 1'b0; c.uses_rt = 1'b0; end
                    endcase
                end
                OP_ADDI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.rn_sel = RN_RT; end
                OP_ANDI: begin
                    c.wreg = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.rn_sel = RN_RT;
                    c.zext = 1'b1; c.aluc = ALU_AND;
                end
                OP_ORI: begin
                    c.wreg = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.rn_sel = RN_RT;
                    c.zext = 1'b1; c.aluc = ALU_OR;
                end
                OP_XORI: begin
                    c.wreg = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.rn_sel = RN_RT;
                    c.zext = 1'b1; c.aluc = ALU_XOR;
                end
                OP_LUI: begin c.wreg = 1'b1; c.aluimm = 1'b1; c.rn_sel = RN_RT; c.aluc = ALU_LUI; end
                OP_LW: begin
                    c.wreg = 1'b1; c.m2reg = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.rn_sel = RN_RT;
                end
                OP_SW:  begin c.wmem = 1'b1; c.aluimm = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; end
                OP_BEQ: begin c.is_beq = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.aluc = ALU_SUB; end
                OP_BNE: begin c.is_bne = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.aluc = ALU_SUB; end
                OP_J:   c.is_j = 1'b1;
                OP_JAL: begin c.is_j = 1'b1; c.jal = 1'b1; c.wreg = 1'b1; c.rn_sel = RN_31; end
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_id_regfile.sv
// 2R/1W register file, r0 hard-wired to zero; a read of the register being
// written this cycle returns the write data so WB->ID needs no extra bubble.
module pipe_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);
    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == '0)                      rd1_o = '0;
        else if (we_i && (wa_i == ra1_i))     rd1_o = wd_i;
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == '0)                      rd2_o = '0;
        else if (we_i && (wa_i == ra2_i))     rd2_o = wd_i;
    end

endmodule

// File: rtl/pipe_id.sv
// ID stage: IF/ID register, decode, EX/MEM forwarding, load-use stall and
// branch/jump resolution with a single delay slot (no flush).
module pipe_id
    import pipe_defs::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] if_pc4,
    input  logic [DW-1:0] if_inst,
    input  logic [AW-1:0] ex_rn,
    input  logic          ex_wreg,
    input  logic          ex_m2reg,
    input  logic [DW-1:0] ex_alu,
    input  logic [AW-1:0] mem_rn,
    input  logic          mem_wreg,
    input  logic          mem_m2reg,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] mem_mdata,
    input  logic [AW-1:0] wb_rn,
    input  logic          wb_we,
    input  logic [DW-1:0] wb_data,
    output logic          stall,
    output logic [1:0]    pcsrc,
    output logic [DW-1:0] bpc,
    output logic [DW-1:0] jpc,
    output logic [DW-1:0] rpc,
    output logic [DW-1:0] id_a,
    output logic [DW-1:0] id_b,
    output logic [DW-1:0] id_imm,
    output logic [AW-1:0] id_rn,
    output logic          id_wreg,
    output logic          id_m2reg,
    output logic          id_wmem,
    output logic          id_aluimm,
    output logic          id_shift,
    output logic          id_jal,
    output logic [3:0]    id_aluc,
    output logic [DW-1:0] id_pc4
);
    logic [DW-1:0] inst_q, inst_d, pc4_q, pc4_d;

    assign inst_d = stall ? inst_q : if_inst;
    assign pc4_d  = stall ? pc4_q  : if_pc4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_q <= '0;
            pc4_q  <= '0;
        end else begin
            inst_q <= inst_d;
            pc4_q  <= pc4_d;
        end
    end

    ctrl_t         ctrl;
    logic [AW-1:0] rs, rt, rd;
    logic [15:0]   imm16;

    assign ctrl  = decode(inst_q[31:0]);
    assign rs    = AW'(inst_q[25:21]);
    assign rt    = AW'(inst_q[20:16]);
    assign rd    = AW'(inst_q[15:11]);
    assign imm16 = inst_q[15:0];

    logic [1:0][AW-1:0] src_r;
    logic [1:0][DW-1:0] rf_rd, fwd_v;

    assign src_r[0] = rs;
    assign src_r[1] = rt;

    pipe_regfile #(.DW(DW), .AW(AW)) u_rf (
        .clk    (clk),
        .resetn (resetn),
        .ra1_i  (rs),
        .ra2_i  (rt),
        .rd1_o  (rf_rd[0]),
        .rd2_o  (rf_rd[1]),
        .we_i   (wb_we),
        .wa_i   (wb_rn),
        .wd_i   (wb_data)
    );

    // A load in EX has no data yet, so it is never a forwarding source; the
    // stall below covers that case until the load reaches MEM.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_v[p] = rf_rd[p];
            if (ex_wreg && !ex_m2reg && (ex_rn == src_r[p]) && (src_r[p] != '0))
                fwd_v[p] = ex_alu;
            else if (mem_wreg && (mem_rn == src_r[p]) && (src_r[p] != '0))
                fwd_v[p] = mem_m2reg ? mem_mdata : mem_alu;
        end
    end

    assign stall = ex_wreg && ex_m2reg && (ex_rn != '0) &&
                   (((ex_rn == rs) && ctrl.uses_rs) || ((ex_rn == rt) && ctrl.uses_rt));

    logic [DW-1:0] sext_imm;
    logic          ops_eq;
    pcsrc_e        pcsrc_sel;

    assign sext_imm = {{(DW-16){imm16[15]}}, imm16};
    assign ops_eq   = (fwd_v[0] == fwd_v[1]);

    always_comb begin
        pcsrc_sel = PC_SEQ;
        if (!stall) begin
            if (ctrl.is_jr)                                           pcsrc_sel = PC_JR;
            else if (ctrl.is_j)                                       pcsrc_sel = PC_JMP;
            else if ((ctrl.is_beq && ops_eq) || (ctrl.is_bne && !ops_eq)) pcsrc_sel = PC_BR;
        end
    end

    always_comb begin
        case (ctrl.rn_sel)
            RN_RT:   id_rn = rt;
            RN_31:   id_rn = '1;
            default: id_rn = rd;
        endcase
    end

    assign pcsrc     = pcsrc_sel;
    assign bpc       = pc4_q + {sext_imm[DW-3:0], 2'b00};
    assign jpc       = {pc4_q[DW-1:DW-4], inst_q[25:0], 2'b00};
    assign rpc       = fwd_v[0];
    assign id_a      = fwd_v[0];
    assign id_b      = fwd_v[1];
    assign id_imm    = ctrl.zext ? {{(DW-16){1'b0}}, imm16} : sext_imm;
    assign id_wreg   = ctrl.wreg  && !stall;
    assign id_m2reg  = ctrl.m2reg && !stall;
    assign id_wmem   = ctrl.wmem  && !stall;
    assign id_jal    = ctrl.jal   && !stall;
    assign id_aluimm = ctrl.aluimm;
    assign id_shift  = ctrl.shift;
    assign id_aluc   = ctrl.aluc;
    assign id_pc4    = pc4_q;

endmodule
